// File: rtl/mem_stage_access.sv
// Memory-stage access unit: req/ack data-memory handshake with pipeline stall, lane steering, HI/LO registers.
// Optional macro MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses without issuing a request.
module mem_stage_access #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] MemDataIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic [1:0]  dataTypeIn,
  input  logic [63:0] MultResultIn,
  input  logic        HiLoWriteIn,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [31:0] DMemWData,
  output logic [3:0]  DMemByteEn,
  input  logic        DMemAck,
  input  logic [31:0] DMemRData,
  output logic [31:0] LoadDataOut,
  output logic        LoadValidOut,
  output logic        StallOut,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut,
  output logic        TimeoutErr,
  output logic        MisalignErr
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [15:0] LP_LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_nextState;
  logic [15:0] r_count;
  logic [31:0] r_addr, r_wdata, r_loadData, r_hi, r_lo;
  logic [3:0]  r_byteEn;
  logic [1:0]  r_size;
  logic        r_we, r_timeoutErr, r_misalign;

  logic        w_request, w_inAccess, w_timeout, w_misalign;
  logic [31:0] w_wdata, w_loadData;
  logic [3:0]  w_byteEn;
  logic [7:0]  w_rdByte;
  logic [15:0] w_rdHalf;

  assign w_request  = MemReadIn | MemWriteIn;
  assign w_inAccess = (r_state == ACCESS);
  assign w_timeout  = (r_count == LP_LAST_COUNT);

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = ((dataTypeIn == 2'b01) && ALUResultIn[0]) ||
                      (((dataTypeIn == 2'b00) || (dataTypeIn == 2'b11)) && (ALUResultIn[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Store formatting is resolved at request time so the bus stays stable through ACCESS.
  always_comb begin
    w_wdata  = MemDataIn;
    w_byteEn = 4'b1111;
    if (dataTypeIn == 2'b10) begin
      w_wdata  = {4{MemDataIn[7:0]}};
      w_byteEn = 4'b0001 << ALUResultIn[1:0];
    end else if (dataTypeIn == 2'b01) begin
      w_wdata  = {2{MemDataIn[15:0]}};
      w_byteEn = ALUResultIn[1] ? 4'b1100 : 4'b0011;
    end
  end

  always_comb begin
    case (r_addr[1:0])
      2'b01:   w_rdByte = DMemRData[15:8];
      2'b10:   w_rdByte = DMemRData[23:16];
      2'b11:   w_rdByte = DMemRData[31:24];
      default: w_rdByte = DMemRData[7:0];
    endcase
    w_rdHalf = r_addr[1] ? DMemRData[31:16] : DMemRData[15:0];
    case (r_size)
      2'b10:   w_loadData = {{24{w_rdByte[7]}}, w_rdByte};
      2'b01:   w_loadData = {{16{w_rdHalf[15]}}, w_rdHalf};
      default: w_loadData = DMemRData;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_request) w_nextState = w_misalign ? DONE : ACCESS;
      ACCESS:  if (DMemAck || w_timeout) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_byteEn     <= '0;
      r_size       <= '0;
      r_we         <= 1'b0;
      r_misalign   <= 1'b0;
      r_loadData   <= '0;
      r_timeoutErr <= 1'b0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          r_count <= '0;
          if (w_request) begin
            r_addr     <= ALUResultIn;
            r_wdata    <= w_wdata;
            r_byteEn   <= w_byteEn;
            r_size     <= dataTypeIn;
            r_we       <= MemWriteIn;
            r_misalign <= w_misalign;
            if (w_misalign && !MemWriteIn) r_loadData <= '0;
          end
        end
        ACCESS: begin
          r_count <= r_count + 16'd1;
          // Ack wins over a timeout landing on the same cycle.
          if (DMemAck) begin
            if (!r_we) r_loadData <= w_loadData;
          end else if (w_timeout) begin
            r_timeoutErr <= 1'b1;
            r_loadData   <= '0;
          end
        end
        default: r_count <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (HiLoWriteIn) begin
      r_hi <= MultResultIn[63:32];
      r_lo <= MultResultIn[31:0];
    end
  end

  assign DMemReq      = w_inAccess;
  assign DMemWe       = w_inAccess & r_we;
  assign DMemAddr     = w_inAccess ? {r_addr[31:2], 2'b00} : 32'd0;
  assign DMemWData    = w_inAccess ? r_wdata : 32'd0;
  assign DMemByteEn   = w_inAccess ? r_byteEn : 4'd0;
  assign StallOut     = ((r_state == IDLE) && w_request) || w_inAccess;
  assign LoadValidOut = (r_state == DONE) && !r_we;
  assign MisalignErr  = (r_state == DONE) && r_misalign;
  assign LoadDataOut  = r_loadData;
  assign TimeoutErr   = r_timeoutErr;
  assign HiOut        = r_hi;
  assign LoOut        = r_lo;

endmodule
